// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC/fetch stage feeding a combinational instruction ROM, with a
//               small {pc, instr} FIFO presented to decode via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_WORDS  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_fault
);

    localparam int          c_PW       = $clog2(QUEUE_DEPTH);
    localparam int          c_CW       = c_PW + 1;
    localparam logic [31:0] c_PC_LIMIT = 32'(IMEM_WORDS * 4);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(QUEUE_DEPTH);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    logic [0:0]      r_state;
    logic [31:0]     r_pc;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_q_pc    [QUEUE_DEPTH];
    logic [31:0]     r_q_instr [QUEUE_DEPTH];

    logic w_pc_illegal;
    logic w_redir_illegal;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_pc_illegal    = (r_pc[1:0] != 2'b00) || (r_pc >= c_PC_LIMIT);
    assign w_redir_illegal = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= c_PC_LIMIT);
    assign w_full          = (r_count == c_FULL);
    assign w_pop           = out_valid && out_ready;
    // A full queue may still accept a push when the head leaves in the same cycle
    assign w_push          = !redirect_valid && (r_state == c_ST_RUN) && !w_pc_illegal
                             && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_RUN;
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_state  <= w_redir_illegal ? c_ST_HALT : c_ST_RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_state == c_ST_RUN && w_pc_illegal) begin
                r_state <= c_ST_HALT;
            end
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_pc;
            r_q_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_addr    = r_pc;
    assign out_valid    = (r_count != '0);
    assign out_pc       = out_valid ? r_q_pc[r_rd_ptr] : 32'h0;
    assign out_instr    = out_valid ? r_q_instr[r_rd_ptr] : 32'h0;
    assign out_pc_plus4 = out_valid ? (r_q_pc[r_rd_ptr] + 32'd4) : 32'h0;
    assign fetch_fault  = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed vector bench for fetch_unit with a behavioural ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2),
        .IMEM_WORDS  (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    // ROM word i holds 0x1000_0000 + i
    assign imem_rdata = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
        logic [31:0] eaddr;
    } vec_t;

    localparam int c_NV = 24;
    vec_t vecs [c_NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic ef, input logic [31:0] eaddr);
        logic [31:0] e_instr;
        logic [31:0] e_plus4;
        e_instr = ev ? (32'h1000_0000 + (epc >> 2)) : 32'h0;
        e_plus4 = ev ? (epc + 32'd4) : 32'h0;
        chk({tag, " valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " pc"}, out_pc, ev ? epc : 32'h0);
        chk({tag, " instr"}, out_instr, e_instr);
        chk({tag, " pc_plus4"}, out_pc_plus4, e_plus4);
        chk({tag, " fault"}, 32'(fetch_fault), 32'(ef));
        chk({tag, " imem_addr"}, imem_addr, eaddr);
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stall with full queue, drain without gap, redirect while full,
        // misaligned redirect and recovery, then run off the end of memory.
        vecs[0]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h04};
        vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h08};
        vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h08};
        vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h08};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h08};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h08};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 1'b0, 32'h0C};
        vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 1'b0, 32'h10};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0C, 1'b0, 32'h14};
        vecs[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h00, 1'b0, 32'h20};
        vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h20, 1'b0, 32'h24};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h20, 1'b0, 32'h28};
        vecs[12] = '{1'b1, 32'h22, 1'b1, 1'b0, 32'h00, 1'b1, 32'h22};
        vecs[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b1, 32'h22};
        vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b1, 32'h22};
        vecs[15] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h00, 1'b0, 32'h10};
        vecs[16] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b0, 32'h14};
        vecs[17] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h14, 1'b0, 32'h18};
        vecs[18] = '{1'b1, 32'hF8, 1'b0, 1'b0, 32'h00, 1'b0, 32'hF8};
        vecs[19] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hF8, 1'b0, 32'hFC};
        vecs[20] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hF8, 1'b0, 32'h100};
        vecs[21] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hF8, 1'b1, 32'h100};
        vecs[22] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hFC, 1'b1, 32'h100};
        vecs[23] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b1, 32'h100};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < c_NV; i++) begin
            step(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            chk_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ef, vecs[i].eaddr);
        end

        // Throughput: consecutive deliveries from reset with out_ready held high
        step(1'b1, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 1'b1);
            chk_all($sformatf("stream%0d", k), 1'b1, 32'(k * 4), 1'b0, 32'((k + 1) * 4));
        end

        // Reset mid-stream while halted with two queued entries
        step(1'b1, 32'hF8, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk_all("pre_rst", 1'b1, 32'hF8, 1'b1, 32'h100);
        rst_n = 1'b0;
        #2;
        chk_all("mid_rst", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        chk_all("post_rst0", 1'b1, 32'h0, 1'b0, 32'h4);
        step(1'b0, 32'h0, 1'b1);
        chk_all("post_rst1", 1'b1, 32'h4, 1'b0, 32'h8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
